// File: rtl/lpm_walk.sv
// lpm_walk: longest-prefix-match style table walk.
// A request {start idx, tag, key} is dequeued in IDLE. WALK consumes one key
// nibble per cycle (MSB first), chasing table pointers until it reaches a leaf
// entry (bit 31 set) or runs out of steps. SEND holds {count, result, tag}
// until the sink accepts it.
// Optional feature: define LPM_WALK_STATS_EN for hit/miss counters.
module lpm_walk #(
  parameter int DEPTH   = 16,
  parameter int MAXSTEP = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [95:0]                in_first,
  input  logic                       in_first__RDY,
  input  logic                       in_deq__RDY,
  output logic                       in_deq__ENA,
  output logic                       out_enq__ENA,
  output logic [95:0]                out_enq_v,
  input  logic                       out_enq__RDY,
  input  logic                       mem_write__ENA,
  input  logic [$clog2(DEPTH)-1:0]   mem_write_addr,
  input  logic [31:0]                mem_write_data,
  output logic                       mem_write__RDY
`ifdef LPM_WALK_STATS_EN
  ,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_misses
`endif
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int SW   = $clog2(MAXSTEP + 1);

  typedef enum logic [1:0] {IDLE, WALK, SEND} state_t;

  state_t          r_state, w_nstate;
  logic            r_rst_q;
  logic [31:0]     r_tbl [DEPTH];
  logic [31:0]     r_key, r_tag, r_result, r_count;
  logic [IDXW-1:0] r_idx, w_nidx;
  logic [SW-1:0]   r_step;
  logic [31:0]     w_e, w_ksh;
  logic [3:0]      w_nib;
  logic            w_leaf, w_last, w_deq, w_enq, w_mem_rdy, w_wr;
  logic            w_unused;

  // Upper start-index bits beyond the table size carry no meaning.
  assign w_unused = ^in_first[95:64+IDXW];

  // Current entry and the key nibble consumed at this step (MSB first).
  assign w_e    = r_tbl[r_idx];
  assign w_ksh  = r_key << ({{(32-SW){1'b0}}, r_step} << 2);
  assign w_nib  = w_ksh[31:28];
  assign w_nidx = IDXW'({{(32-IDXW){1'b0}}, w_e[IDXW-1:0]} + {28'd0, w_nib});
  assign w_leaf = w_e[31];
  assign w_last = (r_step == SW'(MAXSTEP - 1));
  assign w_wr   = mem_write__ENA & w_mem_rdy;

  assign in_deq__ENA    = w_deq;
  assign out_enq__ENA   = w_enq;
  assign mem_write__RDY = w_mem_rdy;
  assign out_enq_v      = RST ? 96'd0 : {r_count, r_result, r_tag};

  // State register; r_rst_q blocks dequeue for the cycle right after reset.
  always_ff @(posedge CLK) begin
    r_rst_q <= RST;
    if (RST) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  // Next state and handshake outputs, all forced quiet while in reset.
  always_comb begin
    w_nstate  = r_state;
    w_deq     = 1'b0;
    w_enq     = 1'b0;
    w_mem_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        w_mem_rdy = 1'b1;
        w_deq     = in_first__RDY & in_deq__RDY & ~r_rst_q;
        if (w_deq) w_nstate = WALK;
      end
      WALK: if (w_leaf || w_last) w_nstate = SEND;
      SEND: begin
        w_enq = 1'b1;
        if (out_enq__RDY) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
    if (RST) begin
      w_deq     = 1'b0;
      w_enq     = 1'b0;
      w_mem_rdy = 1'b0;
    end
  end

  // Route table: loads only while idle; reset clears every entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= 32'h0;
    end else if (w_wr) begin
      r_tbl[mem_write_addr] <= mem_write_data;
    end
  end

  // Walk datapath: latch request, step through table, capture result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_key    <= '0;
      r_tag    <= '0;
      r_idx    <= '0;
      r_step   <= '0;
      r_result <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_deq) begin
          r_key  <= in_first[31:0];
          r_tag  <= in_first[63:32];
          r_idx  <= in_first[64 +: IDXW];
          r_step <= '0;
        end
        WALK: begin
          if (w_leaf) begin
            r_result <= {1'b0, w_e[30:0]};
            r_count  <= {{(32-SW){1'b0}}, r_step} + 32'd1;
          end else if (w_last) begin
            r_result <= 32'hFFFF_FFFF;
            r_count  <= 32'(MAXSTEP);
          end else begin
            r_idx  <= w_nidx;
            r_step <= r_step + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LPM_WALK_STATS_EN
  logic [31:0] r_hits, r_misses;
  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;

  // Count completed results; a miss result is the only one with bit 31 set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_state == SEND && out_enq__RDY) begin
      if (r_result[31]) r_misses <= r_misses + 32'd1;
      else              r_hits   <= r_hits + 32'd1;
    end
  end
`endif
endmodule

// File: doc/lpm_walk.md
LPM_WALK -- requirements
Module: lpm_walk

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning route-table entries (power of two; index width IDXW = log2(DEPTH) = 4).
REQ-002 SHALL have parameter MAXSTEP, default 8, meaning the walk step limit (one 4-bit key nibble per step, 32-bit key).
REQ-003 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports in$first  input  96, in$first__RDY  input  1, in$deq__RDY  input  1, in$deq__ENA  output  1: request source (upstream FIFO head), v = {c, b, a} with a = key[95..64 order: a at bits 31:0], b = tag at bits 63:32, c = start index at bits 95:64.
REQ-006 SHALL have ports out$enq__ENA  output  1, out$enq$v  output  96, out$enq__RDY  input  1: result sink, v = {count[95:64], result[63:32], tag[31:0]}.
REQ-007 SHALL have ports mem$write__ENA  input  1, mem$write$addr  input  IDXW, mem$write$data  input  32, mem$write__RDY  output  1: table load.
REQ-008 SHALL have, only with LPM_WALK_STATS_EN, ports stat$hits  output  32 and stat$misses  output  32.

Function
REQ-009 SHALL implement states IDLE, WALK, SEND; reset state IDLE.
REQ-010 SHALL drive in$deq__ENA = (state==IDLE) & in$first__RDY & in$deq__RDY, combinationally; on that cycle SHALL latch key=a, tag=b, idx=c[IDXW-1:0], step=0, and enter WALK.
REQ-011 In WALK, SHALL read entry e = table[idx] combinationally, one step per cycle.
REQ-012 If e[31]==1 (leaf): result <= {1'b0, e[30:0]}, count <= step+1, state <= SEND.
REQ-013 If e[31]==0 and step==MAXSTEP-1: result <= 32'hFFFF_FFFF, count <= MAXSTEP, state <= SEND (miss).
REQ-014 Otherwise: idx <= (e[IDXW-1:0] + key[31-4*step -: 4]) mod DEPTH, step <= step+1; nibble addition wraps, no carry kept.
REQ-015 Leaf found at step s SHALL put out$enq__ENA high exactly s+2 cycles after the dequeue cycle; miss after MAXSTEP+1 cycles.
REQ-016 SHALL drive out$enq__ENA = (state==SEND); out$enq$v stable while in SEND; on out$enq__RDY high in SEND SHALL return to IDLE next cycle.
REQ-017 SHALL not dequeue in the cycle SEND completes (minimum one IDLE cycle between requests).
REQ-018 SHALL drive mem$write__RDY = (state==IDLE); write takes effect at the edge when mem$write__ENA & mem$write__RDY; mem$write__ENA while not ready SHALL be ignored.
REQ-019 Write and dequeue in the same IDLE cycle SHALL both occur; the walk SHALL observe the new entry from its first WALK cycle.
REQ-020 Entry with e[31]==0 and next index equal to current SHALL be legal; walk continues until leaf or MAXSTEP.

Reset
REQ-021 RST high at an edge SHALL force state IDLE, step, idx, key, tag, result, count to 0 and every table entry to 32'h0, regardless of state; an in-progress walk SHALL be dropped with no output.
REQ-022 During and one cycle after reset: in$deq__ENA=0, out$enq__ENA=0, out$enq$v=0; mem$write__RDY=1 after reset deasserts.

Configuration
REQ-023 Macro LPM_WALK_STATS_EN defined: stat$hits/stat$misses SHALL increment (wrapping at 2^32) on each SEND handshake completing a leaf/miss result; reset to 0.
REQ-024 Macro LPM_WALK_STATS_EN undefined: stat ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-025 Leaf at start: table[3]=32'h8000_0055, request c=3,b=7,a=0 -> out$enq$v={1,32'h55,7} two cycles after dequeue.
REQ-026 Two-step walk: table[2]=32'h0000_0001, table[6]=32'h8000_00AA, c=2, a=32'h5000_0000 -> idx 1+5=6, result 32'hAA, count 2, ENA 3 cycles after dequeue.
REQ-027 Miss: empty table (post-reset), any request -> result 32'hFFFF_FFFF, count 8, ENA 9 cycles after dequeue; stat$misses=1 with macro.
REQ-028 Backpressure: out$enq__RDY low 5 cycles in SEND -> value held, in$deq__ENA=0, mem$write__RDY=0 throughout; one result per request.
REQ-029 Reset mid-walk: RST at step 3 -> no output, table cleared, next request after reset misses.
REQ-030 Wrap: table[15]=32'h0000_000F, c=15, a=32'h1000_0000 -> idx (15+1) mod 16 = 0, table[0]=32'h8000_0001 -> result 1, count 2.
